ram_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 32-bit word RAM.
- Serializes read/write requests from the instruction-fetch port (port 0) and the data-access port (port 1).
- Drives the RAM Enable/MOV/RW strobes and completes each transfer on the RAM's MOC acknowledge.
- Sits between the CPU control unit and the RAM; it is the only block that drives the RAM.

---
 rtl/ram_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared word RAM (IDLE/SETUP/STROBE/DONE).
// Optional MOC timeout abort is enabled by defining RAM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps

module ram_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_rw,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic          p1_rw,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,

    output logic          ram_enable,
    output logic          ram_mov,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic          ram_moc,
    input  logic [DW-1:0] ram_dout,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic owner;
    logic last;
    logic grant;
    logic take;
    logic strobe_end;
    logic timeout_hit;

    logic moc_tgl;
    logic moc_ack;
    logic moc_seen;
    logic moc_armed;

    // Round-robin: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        grant = p1_req;
        if (p0_req && p1_req) begin
            grant = ~last;
        end
    end

    assign take       = (state == IDLE) && (p0_req || p1_req);
    assign strobe_end = (state == STROBE) && (moc_seen || timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ram_enable = 1'b0;
        ram_mov    = 1'b0;
        busy       = 1'b1;
        p0_done    = 1'b0;
        p1_done    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (p0_req || p1_req) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                ram_enable = 1'b1;
                state_nxt  = STROBE;
            end
            STROBE: begin
                ram_enable = 1'b1;
                ram_mov    = 1'b1;
                if (moc_seen || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                p0_done   = ~owner;
                p1_done   = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch: the RAM-side address/data hold from SETUP through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            ram_rw   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            if (take) begin
                owner    <= grant;
                ram_rw   <= grant ? p1_rw    : p0_rw;
                ram_addr <= grant ? p1_addr  : p0_addr;
                ram_din  <= grant ? p1_wdata : p0_wdata;
            end
            if (state == DONE) begin
                last <= owner;
            end
        end
    end

    // MOC may be shorter than a clock period, so it is caught on its own edge.
    // A toggle pair avoids a second driver: the clk side re-aligns moc_ack in SETUP.
    assign moc_armed = (state == STROBE);
    assign moc_seen  = moc_tgl ^ moc_ack;

    always_ff @(posedge ram_moc or negedge rst_n) begin
        if (!rst_n) begin
            moc_tgl <= 1'b0;
        end else if (moc_armed && !moc_seen) begin
            moc_tgl <= ~moc_tgl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moc_ack <= 1'b0;
        end else if (state == SETUP) begin
            moc_ack <= moc_tgl;
        end
    end

    // Read data is loaded as STROBE ends so it is already valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (strobe_end) begin
            if (!owner) begin
                if (timeout_hit) begin
                    p0_rdata <= '0;
                end else if (ram_rw) begin
                    p0_rdata <= ram_dout;
                end
            end else begin
                if (timeout_hit) begin
                    p1_rdata <= '0;
                end else if (ram_rw) begin
                    p1_rdata <= ram_dout;
                end
            end
        end
    end

`ifdef RAM_ARB_TIMEOUT_EN
    logic [7:0] strobe_cnt;
    logic       p0_err_r;
    logic       p1_err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt <= '0;
        end else if (state == SETUP) begin
            strobe_cnt <= '0;
        end else if (state == STROBE) begin
            strobe_cnt <= strobe_cnt + 8'd1;
        end
    end

    // Fires in the TIMEOUT-th STROBE cycle so DONE follows exactly TIMEOUT strobe cycles.
    assign timeout_hit = (state == STROBE) && !moc_seen && (strobe_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_err_r <= 1'b0;
            p1_err_r <= 1'b0;
        end else begin
            if (take && !grant) begin
                p0_err_r <= 1'b0;
            end else if (strobe_end && timeout_hit && !owner) begin
                p0_err_r <= 1'b1;
            end
            if (take && grant) begin
                p1_err_r <= 1'b0;
            end else if (strobe_end && timeout_hit && owner) begin
                p1_err_r <= 1'b1;
            end
        end
    end

    assign p0_err = p0_err_r;
    assign p1_err = p1_err_r;
`else
    assign timeout_hit = 1'b0;
    assign p0_err      = 1'b0;
    assign p1_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM answering MOC.
`timescale 1ns/1ps

module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          p0_req, p0_rw, p1_req, p1_rw;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_done, p1_done, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_enable, ram_mov, ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_moc;
    logic          moc_model;
    logic          moc_idle;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    int moc_delay = 1;

    logic [DW-1:0] mem [0:255];

    assign ram_moc = moc_model | moc_idle;

    ram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .ram_enable(ram_enable), .ram_mov(ram_mov), .ram_rw(ram_rw),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_moc(ram_moc), .ram_dout(ram_dout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model: answers with a short MOC pulse in the moc_delay-th STROBE cycle (0 = never).
    initial begin
        int  scnt;
        bit  answered;
        scnt      = 0;
        answered  = 0;
        moc_model = 1'b0;
        ram_dout  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (ram_enable && ram_mov) begin
                if (!answered) begin
                    scnt++;
                    if (moc_delay != 0 && scnt == moc_delay) begin
                        if (ram_rw) ram_dout = mem[ram_addr];
                        else        mem[ram_addr] = ram_din;
                        #1 moc_model = 1'b1;
                        #2 moc_model = 1'b0;
                        answered = 1;
                    end
                end
            end else begin
                scnt     = 0;
                answered = 0;
            end
        end
    end

    task automatic run_txn(input bit port, input bit rw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int dly,
                           output int lat, output int movs, output logic [DW-1:0] rdata,
                           output logic err, output logic [AW-1:0] addr_done,
                           output logic done_after);
        bit seen;
        @(posedge clk);
        #1;
        moc_delay = dly;
        if (!port) begin
            p0_rw = rw; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end else begin
            p1_rw = rw; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end
        lat = 0; movs = 0; seen = 0;
        rdata = '0; err = 1'b0; addr_done = '0; done_after = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ram_mov) movs++;
            if ((!port && p0_done) || (port && p1_done)) begin
                seen      = 1;
                rdata     = port ? p1_rdata : p0_rdata;
                err       = port ? p1_err : p0_err;
                addr_done = ram_addr;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clk);
        done_after = port ? p1_done : p0_done;
    endtask

    initial begin
        int            lat, movs;
        logic [DW-1:0] rd;
        logic          er, da;
        logic [AW-1:0] ad;
        logic [15:0]   hist0, hist1;
        bit            done_in_rst;

        for (int i = 0; i < 256; i++) mem[i] = 32'hC0FFEE00 | 32'(i);
        moc_idle = 1'b0;
        p0_req = 0; p0_rw = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_rw = 0; p1_addr = '0; p1_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({ram_enable, ram_mov, ram_rw, ram_addr, busy, p0_done, p1_done, p0_err, p1_err}), 64'd0);
        check("reset_rdata", {p0_rdata, p1_rdata}, 64'd0);
        rst_n = 1'b1;

        // Tie right after reset: port 0 first, then strict alternation, dones 4 cycles apart.
        @(posedge clk);
        #1;
        moc_delay = 1;
        p0_rw = 1; p0_addr = 8'h20; p1_rw = 1; p1_addr = 8'h21;
        p0_req = 1; p1_req = 1;
        hist0 = '0; hist1 = '0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            hist0[c-1] = p0_done;
            hist1[c-1] = p1_done;
            if (c == 15) begin p0_req = 0; p1_req = 0; end
        end
        check("tie_p0_done_cycles", 64'(hist0), 64'h0404);
        check("tie_p1_done_cycles", 64'(hist1), 64'h4040);
        check("tie_p0_rdata", 64'(p0_rdata), 64'hC0FFEE20);
        check("tie_p1_rdata", 64'(p1_rdata), 64'hC0FFEE21);

        // Port 1 write; a write leaves rdata unchanged.
        run_txn(1, 0, 8'h10, 32'hDEADBEEF, 1, lat, movs, rd, er, ad, da);
        check("wr_latency", 64'(lat), 64'd3);
        check("wr_rdata_hold", 64'(rd), 64'hC0FFEE21);
        check("wr_err", 64'(er), 64'd0);
        check("wr_done_one_cycle", 64'(da), 64'd0);

        // Port 0 reads back the written word, minimum latency.
        run_txn(0, 1, 8'h10, 32'h0, 1, lat, movs, rd, er, ad, da);
        check("rd_latency", 64'(lat), 64'd3);
        check("rd_rdata", 64'(rd), 64'hDEADBEEF);
        check("rd_addr_held", 64'(ad), 64'h10);
        check("rd_mov_cycles", 64'(movs), 64'd1);
        check("rd_other_port_rdata", 64'(p1_rdata), 64'hC0FFEE21);

        // MOC five cycles late: each extra STROBE cycle adds one cycle of latency.
        run_txn(1, 1, 8'h10, 32'h0, 6, lat, movs, rd, er, ad, da);
        check("late_latency", 64'(lat), 64'd8);
        check("late_mov_cycles", 64'(movs), 64'd6);
        check("late_rdata", 64'(rd), 64'hDEADBEEF);

        // A MOC pulse in IDLE must not be remembered for the next transfer.
        moc_idle = 1'b1;
        #2 moc_idle = 1'b0;
        @(negedge clk);
        check("idle_moc_busy", 64'(busy), 64'd0);
        run_txn(0, 1, 8'h30, 32'h0, 3, lat, movs, rd, er, ad, da);
        check("idle_moc_latency", 64'(lat), 64'd5);
        check("idle_moc_rdata", 64'(rd), 64'hC0FFEE30);

        // Reset in the middle of STROBE drops the strobes at once and suppresses done.
        @(posedge clk);
        #1;
        moc_delay = 0;
        p0_rw = 1; p0_addr = 8'h40; p0_req = 1;
        for (int c = 0; c < 10 && !ram_mov; c++) @(negedge clk);
        check("rst_reached_strobe", 64'(ram_mov), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_strobes", 64'({ram_enable, ram_mov, busy}), 64'd0);
        done_in_rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (p0_done || p1_done) done_in_rst = 1;
        end
        check("rst_no_done", 64'(done_in_rst), 64'd0);
        check("rst_rdata_cleared", 64'(p0_rdata), 64'd0);
        p0_req = 0;
        rst_n = 1'b1;

`ifdef RAM_ARB_TIMEOUT_EN
        // No MOC at all: abort after TIMEOUT=4 strobe cycles with err and zero data.
        run_txn(1, 1, 8'h31, 32'h0, 0, lat, movs, rd, er, ad, da);
        check("to_latency", 64'(lat), 64'd6);
        check("to_err", 64'(er), 64'd1);
        check("to_rdata", 64'(rd), 64'd0);
        check("to_other_err", 64'(p0_err), 64'd0);
        run_txn(1, 1, 8'h31, 32'h0, 1, lat, movs, rd, er, ad, da);
        check("to_err_cleared", 64'(er), 64'd0);
        check("to_recover_rdata", 64'(rd), 64'hC0FFEE31);
`else
        run_txn(1, 1, 8'h31, 32'h0, 2, lat, movs, rd, er, ad, da);
        check("post_rst_latency", 64'(lat), 64'd4);
        check("post_rst_err", 64'(er), 64'd0);
        check("post_rst_rdata", 64'(rd), 64'hC0FFEE31);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
